// File: rtl/go_done_sequencer.sv
// Initiator side of the go/done handshake: runs the worker RUNS times per start request,
// with a synchronised done input, idle gaps between runs and a per-run timeout.
module go_done_sequencer #(
    parameter int unsigned RUNS           = 4,
    parameter int unsigned GAP_CYCLES     = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       done_in,
    output logic       go_n,
    output logic       busy,
    output logic       all_done,
    output logic       timeout_err,
    output logic [7:0] run_count
);

    // Timeout counter is sized from TIMEOUT_CYCLES so the 50M default fits without truncation.
    localparam int unsigned       TMO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [23:0]       GAP_LAST = (GAP_CYCLES > 1) ? 24'(GAP_CYCLES - 1) : 24'd0;
    localparam logic [7:0]        RUNS_C   = 8'(RUNS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_RELEASE,
        S_GAP,
        S_FINISH,
        S_ERROR
    } state_t;

    state_t           state;
    logic             start_q;
    logic             done_sync_p0;
    logic             done_sync_p1;
    logic [TMO_W-1:0] tmo;
    logic [23:0]      gap;

    logic       done_s;
    logic       start_rise;
    logic [7:0] run_next;

    assign done_s     = done_sync_p1;
    assign start_rise = start & ~start_q;
    assign run_next   = run_count + 8'd1;

    assign go_n     = (state != S_ISSUE);
    assign busy     = (state == S_ISSUE) || (state == S_RELEASE) || (state == S_GAP);
    assign all_done = (state == S_FINISH);

    always_ff @(posedge clk) begin
        // Sampled even in reset, so a start held through reset is not a fresh request.
        start_q <= start;
        if (rst) begin
            done_sync_p0 <= 1'b0;
            done_sync_p1 <= 1'b0;
            state        <= S_IDLE;
            run_count    <= 8'd0;
            timeout_err  <= 1'b0;
            tmo          <= '0;
            gap          <= 24'd0;
        end else begin
            // done_in crosses into clk: p0 -> p1
            done_sync_p0 <= done_in;
            done_sync_p1 <= done_sync_p0;

            if (abort) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_rise) begin
                            state       <= S_ISSUE;
                            run_count   <= 8'd0;
                            timeout_err <= 1'b0;
                            tmo         <= '0;
                        end
                    end
                    S_ISSUE: begin
                        if (done_s) begin
                            state <= S_RELEASE;
                            tmo   <= '0;
                        end else if (tmo == TMO_LAST) begin
                            state       <= S_ERROR;
                            timeout_err <= 1'b1;
                        end else begin
                            tmo <= tmo + TMO_W'(1);
                        end
                    end
                    S_RELEASE: begin
                        if (!done_s) begin
                            run_count <= run_next;
                            if (run_next == RUNS_C) begin
                                state <= S_FINISH;
                            end else begin
                                state <= S_GAP;
                                gap   <= 24'd0;
                            end
                        end else if (tmo == TMO_LAST) begin
                            state       <= S_ERROR;
                            timeout_err <= 1'b1;
                        end else begin
                            tmo <= tmo + TMO_W'(1);
                        end
                    end
                    S_GAP: begin
                        if (gap == GAP_LAST) begin
                            state <= S_ISSUE;
                            tmo   <= '0;
                        end else begin
                            gap <= gap + 24'd1;
                        end
                    end
                    S_FINISH: begin
                        state <= S_IDLE;
                    end
                    S_ERROR: begin
                        if (start_rise) begin
                            state       <= S_ISSUE;
                            run_count   <= 8'd0;
                            timeout_err <= 1'b0;
                            tmo         <= '0;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_go_done_sequencer.sv
// Directed bench for go_done_sequencer: instance a (RUNS=2, GAP=4, TIMEOUT=20) and
// instance b (RUNS=3, GAP=0, TIMEOUT=20). Outputs are sampled on the falling clock edge.
module tb_go_done_sequencer;

    logic clk;
    logic rst;

    logic       start_a, abort_a, done_a;
    logic       go_n_a, busy_a, all_done_a, timeout_err_a;
    logic [7:0] run_count_a;

    logic       start_b, abort_b, done_b;
    logic       go_n_b, busy_b, all_done_b, timeout_err_b;
    logic [7:0] run_count_b;

    int n_cmp;
    int n_bad;

    go_done_sequencer #(
        .RUNS(2), .GAP_CYCLES(4), .TIMEOUT_CYCLES(20)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .done_in(done_a),
        .go_n(go_n_a), .busy(busy_a), .all_done(all_done_a),
        .timeout_err(timeout_err_a), .run_count(run_count_a)
    );

    go_done_sequencer #(
        .RUNS(3), .GAP_CYCLES(0), .TIMEOUT_CYCLES(20)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .done_in(done_b),
        .go_n(go_n_b), .busy(busy_b), .all_done(all_done_b),
        .timeout_err(timeout_err_b), .run_count(run_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Worker model: raises done 10 cycles into each go_n low window, holds it for 6.
    task automatic drive_worker(input bit sel, input int ncyc, input bit keep_start,
                                output int windows, output int lows, output int pulses,
                                output int period, output logic [7:0] rc_win2,
                                output logic [7:0] rc_end);
        int   lowcnt;
        int   hold;
        int   last_start;
        logic g;
        logic ad;
        windows = 0; lows = 0; pulses = 0; period = -1; rc_win2 = 8'hff;
        lowcnt = 0; hold = 0; last_start = -1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (!keep_start) begin
                if (sel) start_b = 1'b0; else start_a = 1'b0;
            end
            g  = sel ? go_n_b : go_n_a;
            ad = sel ? all_done_b : all_done_a;
            if (ad) pulses++;
            if (hold > 0) begin
                hold--;
                if (hold == 0) begin
                    if (sel) done_b = 1'b0; else done_a = 1'b0;
                end
            end
            if (!g) begin
                if (lowcnt == 0) begin
                    windows++;
                    if (last_start >= 0) period = c - last_start;
                    last_start = c;
                    if (windows == 2) rc_win2 = sel ? run_count_b : run_count_a;
                end
                lowcnt++;
                lows++;
                if (lowcnt == 10) begin
                    if (sel) done_b = 1'b1; else done_a = 1'b1;
                    hold = 6;
                end
            end else begin
                lowcnt = 0;
            end
        end
        rc_end = sel ? run_count_b : run_count_a;
    endtask

    task automatic settle_a();
        done_a  = 1'b0;
        start_a = 1'b0;
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_a = 0; abort_a = 0; done_a = 0;
        start_b = 0; abort_b = 0; done_b = 0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({go_n_a, busy_a, all_done_a, timeout_err_a, run_count_a} !== 12'b1000_0000_0000) begin
            n_bad++;
            $display("FAIL reset_a: got %b want %b",
                     {go_n_a, busy_a, all_done_a, timeout_err_a, run_count_a}, 12'b1000_0000_0000);
        end
        n_cmp++;
        if ({go_n_b, busy_b, all_done_b, timeout_err_b, run_count_b} !== 12'b1000_0000_0000) begin
            n_bad++;
            $display("FAIL reset_b: got %b want %b",
                     {go_n_b, busy_b, all_done_b, timeout_err_b, run_count_b}, 12'b1000_0000_0000);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_two_runs();
        int w, l, p, per;
        logic [7:0] rc2, rce;
        start_a = 1'b1;
        drive_worker(1'b0, 60, 1'b0, w, l, p, per, rc2, rce);
        n_cmp++;
        if (w !== 2) begin n_bad++; $display("FAIL t1_windows: got %0d want 2", w); end
        n_cmp++;
        if (l !== 24) begin n_bad++; $display("FAIL t1_low_cycles: got %0d want 24", l); end
        n_cmp++;
        if (per !== 22) begin n_bad++; $display("FAIL t1_run_period: got %0d want 22", per); end
        n_cmp++;
        if (p !== 1) begin n_bad++; $display("FAIL t1_all_done_pulses: got %0d want 1", p); end
        n_cmp++;
        if (rc2 !== 8'd1) begin n_bad++; $display("FAIL t1_run_count_mid: got %0d want 1", rc2); end
        n_cmp++;
        if (rce !== 8'd2) begin n_bad++; $display("FAIL t1_run_count_end: got %0d want 2", rce); end
        n_cmp++;
        if ({go_n_a, busy_a, all_done_a, timeout_err_a} !== 4'b1000) begin
            n_bad++;
            $display("FAIL t1_idle_after: got %b want 1000", {go_n_a, busy_a, all_done_a, timeout_err_a});
        end
    endtask

    task automatic test_timeout();
        int lows;
        lows = 0;
        start_a = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (!go_n_a) lows++;
        end
        n_cmp++;
        if (lows !== 20) begin n_bad++; $display("FAIL t2_go_low_cycles: got %0d want 20", lows); end
        n_cmp++;
        if ({go_n_a, busy_a, all_done_a, timeout_err_a, run_count_a} !== 12'b1001_0000_0000) begin
            n_bad++;
            $display("FAIL t2_error_state: got %b want 100100000000",
                     {go_n_a, busy_a, all_done_a, timeout_err_a, run_count_a});
        end
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n_cmp++;
        if ({go_n_a, busy_a, timeout_err_a} !== 3'b010) begin
            n_bad++;
            $display("FAIL t2_restart: got %b want 010", {go_n_a, busy_a, timeout_err_a});
        end
        settle_a();
    endtask

    task automatic test_timeout_boundary();
        // done arriving at sample 18 reaches the FSM exactly when tmo==19
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (17) @(negedge clk);
        done_a = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({go_n_a, busy_a, all_done_a, timeout_err_a} !== 4'b1100) begin
            n_bad++;
            $display("FAIL t3_exit_wins: got %b want 1100", {go_n_a, busy_a, all_done_a, timeout_err_a});
        end
        settle_a();
        // one cycle later is too late
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (18) @(negedge clk);
        done_a = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({go_n_a, busy_a, all_done_a, timeout_err_a} !== 4'b1001) begin
            n_bad++;
            $display("FAIL t3_late_done: got %b want 1001", {go_n_a, busy_a, all_done_a, timeout_err_a});
        end
        settle_a();
    endtask

    task automatic test_abort();
        int events;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (9) @(negedge clk);
        done_a = 1'b1;
        repeat (6) @(negedge clk);
        done_a = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({go_n_a, busy_a, run_count_a} !== {1'b1, 1'b1, 8'd1}) begin
            n_bad++;
            $display("FAIL t4_in_gap: got %b want %b", {go_n_a, busy_a, run_count_a}, {1'b1, 1'b1, 8'd1});
        end
        abort_a = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({go_n_a, busy_a, all_done_a, timeout_err_a, run_count_a} !== {4'b1000, 8'd1}) begin
            n_bad++;
            $display("FAIL t4_aborted: got %b want %b",
                     {go_n_a, busy_a, all_done_a, timeout_err_a, run_count_a}, {4'b1000, 8'd1});
        end
        abort_a = 1'b0;
        events = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (all_done_a || !go_n_a) events++;
        end
        n_cmp++;
        if (events !== 0) begin n_bad++; $display("FAIL t4_stays_idle: got %0d events want 0", events); end
        start_a = 1'b1;
        abort_a = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({go_n_a, busy_a, run_count_a} !== {1'b1, 1'b0, 8'd1}) begin
            n_bad++;
            $display("FAIL t4_abort_beats_start: got %b want %b", {go_n_a, busy_a, run_count_a}, {1'b1, 1'b0, 8'd1});
        end
        abort_a = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({go_n_a, busy_a} !== 2'b10) begin
            n_bad++;
            $display("FAIL t4_held_start_no_rise: got %b want 10", {go_n_a, busy_a});
        end
        start_a = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_start_held();
        int w, l, p, per;
        logic [7:0] rc2, rce;
        start_a = 1'b1;
        drive_worker(1'b0, 90, 1'b1, w, l, p, per, rc2, rce);
        n_cmp++;
        if (w !== 2) begin n_bad++; $display("FAIL t5_held_windows: got %0d want 2", w); end
        n_cmp++;
        if (p !== 1) begin n_bad++; $display("FAIL t5_held_pulses: got %0d want 1", p); end
        start_a = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_rst_mid_run();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (9) @(negedge clk);
        done_a = 1'b1;
        repeat (6) @(negedge clk);
        done_a = 1'b0;
        repeat (8) @(negedge clk);
        n_cmp++;
        if ({go_n_a, busy_a, run_count_a} !== {1'b0, 1'b1, 8'd1}) begin
            n_bad++;
            $display("FAIL t5_second_issue: got %b want %b", {go_n_a, busy_a, run_count_a}, {1'b0, 1'b1, 8'd1});
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({go_n_a, busy_a, all_done_a, timeout_err_a, run_count_a} !== 12'b1000_0000_0000) begin
            n_bad++;
            $display("FAIL t5_rst_mid_run: got %b want 100000000000",
                     {go_n_a, busy_a, all_done_a, timeout_err_a, run_count_a});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_gap_zero();
        int w, l, p, per;
        logic [7:0] rc2, rce;
        start_b = 1'b1;
        drive_worker(1'b1, 70, 1'b0, w, l, p, per, rc2, rce);
        n_cmp++;
        if (w !== 3) begin n_bad++; $display("FAIL t6_windows: got %0d want 3", w); end
        n_cmp++;
        if (per !== 19) begin n_bad++; $display("FAIL t6_run_period: got %0d want 19", per); end
        n_cmp++;
        if (l !== 36) begin n_bad++; $display("FAIL t6_low_cycles: got %0d want 36", l); end
        n_cmp++;
        if ({p[7:0], rc2, rce} !== {8'd1, 8'd1, 8'd3}) begin
            n_bad++;
            $display("FAIL t6_counts: got pulses=%0d mid=%0d end=%0d want 1 1 3", p, rc2, rce);
        end
        n_cmp++;
        if ({go_n_b, busy_b, timeout_err_b} !== 3'b100) begin
            n_bad++;
            $display("FAIL t6_idle_after: got %b want 100", {go_n_b, busy_b, timeout_err_b});
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_two_runs();
        test_timeout();
        test_timeout_boundary();
        test_abort();
        test_start_held();
        test_rst_mid_run();
        test_gap_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
